// File: rtl/dcache_ctrl.sv
// Data-cache controller sitting in front of NUM_LINES dcache_line instances.
// Broadcasts CPU requests to every line, resolves hit/miss, picks a victim by
// TTL ageing, multiplexes the owner line's memory traffic onto one port, and
// returns read data plus a one-cycle cpu_ack to the core.
// Optional: define DCACHE_CTRL_STATS_EN to add stat_hits/stat_misses counters.
module dcache_ctrl #(
  parameter int NUM_LINES  = 4,
  parameter int TTLBITS    = 8,
  parameter int MAXTTL     = 255,
  parameter int CACHEWORDS = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_datain,
  input  logic                    cpu_rdreq,
  input  logic                    cpu_wrreq,
  output logic [31:0]             cpu_dataout,
  output logic                    cpu_ack,
  output logic [31:0]             dcache_addr,
  output logic [31:0]             dcache_datain,
  output logic                    dcache_rdreq,
  output logic                    dcache_wrreq,
  output logic [NUM_LINES-1:0]    line_fill,
  input  logic [NUM_LINES*32-1:0] line_out,
  input  logic [NUM_LINES-1:0]    line_valid,
  input  logic [NUM_LINES-1:0]    line_miss,
  input  logic [NUM_LINES*32-1:0] line_mem_addr,
  input  logic [NUM_LINES-1:0]    line_mem_rdreq,
  input  logic [NUM_LINES-1:0]    line_mem_wrreq,
  output logic [NUM_LINES-1:0]    line_mem_valid,
  output logic [31:0]             mem_addr,
  output logic                    mem_rdreq,
  output logic                    mem_wrreq,
  input  logic                    mem_valid
`ifdef DCACHE_CTRL_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);

  localparam int IDXW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int BEATW = $clog2(CACHEWORDS + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, FILL, SETTLE, ACK} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   owner;        // line currently owning the memory port
  logic [IDXW-1:0]   hit_q;        // line that hit; spared from ageing in ACK
  logic [IDXW-1:0]   hit_idx, victim, empty_idx, min_idx;
  logic              hit, have_empty;
  logic [TTLBITS-1:0] min_ttl;
  logic [NUM_LINES-1:0] filled;
  logic [TTLBITS-1:0] ttl [NUM_LINES];
  logic [BEATW-1:0]  beat_cnt;
  logic              settle_cnt;
  logic              fill_beat, fill_done;

  // Address and data are pure broadcasts; only the strobes are state-gated.
  assign dcache_addr   = cpu_addr;
  assign dcache_datain = cpu_datain;

  // Write-back flush beats ride on mem_wrreq and do not advance the fill.
  assign fill_beat = (state == FILL) && mem_valid && !line_mem_wrreq[owner];
  assign fill_done = fill_beat && (beat_cnt == BEATW'(CACHEWORDS - 1));

  // Hit line: lowest index that is filled, valid and not missing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (filled[i] && line_valid[i] && !line_miss[i]) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  // Victim: lowest empty line, else lowest index holding the minimum TTL.
  always_comb begin
    have_empty = 1'b0;
    empty_idx  = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!filled[i]) begin
        have_empty = 1'b1;
        empty_idx  = IDXW'(i);
      end
    end
    min_idx = '0;
    min_ttl = ttl[0];
    for (int i = 1; i < NUM_LINES; i++) begin
      if (ttl[i] < min_ttl) begin
        min_ttl = ttl[i];
        min_idx = IDXW'(i);
      end
    end
    victim = have_empty ? empty_idx : min_idx;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nxt      = state;
    cpu_ack        = 1'b0;
    dcache_rdreq   = 1'b0;
    dcache_wrreq   = 1'b0;
    line_fill      = '0;
    line_mem_valid = '0;
    mem_addr       = '0;
    mem_rdreq      = 1'b0;
    mem_wrreq      = 1'b0;
    if (state != IDLE && state != ACK) begin
      dcache_wrreq = cpu_wrreq;
      dcache_rdreq = cpu_rdreq && !cpu_wrreq;
    end
    if (state == FILL || state == SETTLE) begin
      mem_addr  = line_mem_addr[32*int'(owner) +: 32];
      mem_rdreq = line_mem_rdreq[owner];
      mem_wrreq = line_mem_wrreq[owner];
    end
    case (state)
      IDLE: begin
        if (cpu_rdreq || cpu_wrreq) begin
          dcache_wrreq = cpu_wrreq;
          dcache_rdreq = cpu_rdreq && !cpu_wrreq;
          state_nxt    = LOOKUP;
        end
      end
      LOOKUP: state_nxt = hit ? ACK : MISS;
      MISS: begin
        line_fill[victim] = 1'b1;
        state_nxt         = FILL;
      end
      FILL: begin
        line_mem_valid[owner] = mem_valid;
        if (fill_done) state_nxt = SETTLE;
      end
      SETTLE: if (settle_cnt) state_nxt = LOOKUP;
      ACK: begin
        cpu_ack   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, line bookkeeping, TTL ageing and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= '0;
      hit_q       <= '0;
      filled      <= '0;
      beat_cnt    <= '0;
      settle_cnt  <= 1'b0;
      cpu_dataout <= '0;
      // NOTE: ttl is a handful of flops feeding victim selection, not a RAM, so it is reset.
      for (int i = 0; i < NUM_LINES; i++) ttl[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state <= state_nxt;
      case (state)
        LOOKUP: begin
          if (hit) begin
            hit_q        <= hit_idx;
            ttl[hit_idx] <= TTLBITS'(MAXTTL);
            cpu_dataout  <= line_out[32*int'(hit_idx) +: 32];
          end
        end
        MISS: begin
          owner    <= victim;
          beat_cnt <= '0;
        end
        FILL: begin
          if (fill_beat) beat_cnt <= beat_cnt + 1'b1;
          if (fill_done) begin
            filled[owner] <= 1'b1;
            ttl[owner]    <= TTLBITS'(MAXTTL);
            settle_cnt    <= 1'b0;
          end
        end
        SETTLE: begin
          settle_cnt <= !settle_cnt;
          if (settle_cnt) owner <= '0;
        end
        ACK: begin
          for (int i = 0; i < NUM_LINES; i++) begin
            if (IDXW'(i) != hit_q && ttl[i] != '0) ttl[i] <= ttl[i] - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_CTRL_STATS_EN
  // Hit/miss statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit) stat_hits   <= stat_hits + 32'd1;
      else     stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural model of four dcache_line
// instances and a memory that answers every read request with one beat per cycle.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  cpu_addr, cpu_datain, cpu_dataout;
  logic         cpu_rdreq, cpu_wrreq, cpu_ack;
  logic [31:0]  dcache_addr, dcache_datain;
  logic         dcache_rdreq, dcache_wrreq;
  logic [3:0]   line_fill, line_valid, line_miss, line_mem_rdreq, line_mem_wrreq, line_mem_valid;
  logic [127:0] line_out, line_mem_addr;
  logic [31:0]  mem_addr;
  logic         mem_rdreq, mem_wrreq, mem_valid;
`ifdef DCACHE_CTRL_STATS_EN
  logic [31:0]  stat_hits, stat_misses;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  dcache_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_datain(cpu_datain), .cpu_rdreq(cpu_rdreq), .cpu_wrreq(cpu_wrreq),
    .cpu_dataout(cpu_dataout), .cpu_ack(cpu_ack),
    .dcache_addr(dcache_addr), .dcache_datain(dcache_datain),
    .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
    .line_fill(line_fill), .line_out(line_out), .line_valid(line_valid), .line_miss(line_miss),
    .line_mem_addr(line_mem_addr), .line_mem_rdreq(line_mem_rdreq), .line_mem_wrreq(line_mem_wrreq),
    .line_mem_valid(line_mem_valid),
    .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq), .mem_valid(mem_valid)
`ifdef DCACHE_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  // ---------------- line model ----------------
  logic [24:0] l_tag     [4];
  logic        l_vld     [4];
  logic        l_filling [4];
  logic [5:0]  l_beat    [4];
  logic [31:0] l_data    [4][32];
  logic [31:0] lo        [4];
  logic        lv        [4];
  logic        lm        [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      line_out[32*i +: 32]      = lo[i];
      line_valid[i]             = lv[i];
      line_miss[i]              = lm[i];
      line_mem_rdreq[i]         = l_filling[i];
      line_mem_wrreq[i]         = 1'b0;
      line_mem_addr[32*i +: 32] = {l_tag[i], l_beat[i][4:0], 2'b00};
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        l_tag[i] <= '0; l_vld[i] <= 1'b0; l_filling[i] <= 1'b0; l_beat[i] <= '0;
        lo[i] <= '0; lv[i] <= 1'b0; lm[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (dcache_rdreq || dcache_wrreq) begin
          lv[i] <= l_vld[i];
          lm[i] <= !(l_vld[i] && l_tag[i] == dcache_addr[31:7]);
          lo[i] <= l_data[i][dcache_addr[6:2]];
          if (dcache_wrreq && l_vld[i] && l_tag[i] == dcache_addr[31:7])
            l_data[i][dcache_addr[6:2]] <= dcache_datain;
        end
        if (line_fill[i]) begin
          l_tag[i] <= dcache_addr[31:7]; l_vld[i] <= 1'b0; l_filling[i] <= 1'b1; l_beat[i] <= '0;
        end else if (l_filling[i] && line_mem_valid[i]) begin
          l_data[i][l_beat[i][4:0]] <= mem_word({l_tag[i], l_beat[i][4:0], 2'b00});
          l_beat[i] <= l_beat[i] + 6'd1;
          if (l_beat[i] == 6'd31) begin
            l_filling[i] <= 1'b0;
            l_vld[i]     <= 1'b1;
          end
        end
      end
    end
  end

  // One CPU transaction; memory answers one beat per cycle while mem_rdreq is high.
  task automatic cpu_op(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic [3:0] fills,
                        output logic [3:0] lmv, output logic traffic, output int beats);
    logic done;
    @(posedge clk); #1;
    cpu_addr = addr; cpu_datain = wdata; cpu_wrreq = wr; cpu_rdreq = !wr;
    lat = 0; done = 1'b0; fills = '0; lmv = '0; traffic = 1'b0; beats = 0; rdata = '0;
    while (!done && lat < 400) begin
      @(negedge clk); lat++;
      fills   = fills | line_fill;
      traffic = traffic | mem_rdreq | mem_wrreq;
      mem_valid = mem_rdreq;
      #1;
      lmv = lmv | line_mem_valid;
      if (line_mem_valid != 4'b0000) beats++;
      if (cpu_ack) begin rdata = cpu_dataout; done = 1'b1; end
    end
    cpu_rdreq = 1'b0; cpu_wrreq = 1'b0; mem_valid = 1'b0;
    n_checks++;
    if (!done) $display("FAIL timeout addr=%h: no cpu_ack within %0d cycles", addr, lat);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({cpu_ack, dcache_rdreq, dcache_wrreq, line_fill, line_mem_valid, mem_rdreq, mem_wrreq} !== 13'd0)
      $display("FAIL reset_strobes: got %b required 0", {cpu_ack, dcache_rdreq, dcache_wrreq, line_fill, line_mem_valid, mem_rdreq, mem_wrreq});
    else n_pass++;
    n_checks++;
    if (cpu_dataout !== 32'h0) $display("FAIL reset_dataout: got %h required 0", cpu_dataout); else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h required 0", mem_addr); else n_pass++;
`ifdef DCACHE_CTRL_STATS_EN
    n_checks++;
    if ({stat_hits, stat_misses} !== 64'h0) $display("FAIL reset_stats: got %h/%h required 0/0", stat_hits, stat_misses); else n_pass++;
`endif
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cpu_ack, line_fill, mem_rdreq} !== 6'd0) $display("FAIL post_reset_idle: got %b required 0", {cpu_ack, line_fill, mem_rdreq}); else n_pass++;
  endtask

  task automatic test_cold_read();
    int lat, beats; logic [31:0] rd; logic [3:0] f, m; logic t;
    cpu_op(32'h0000_1000, 1'b0, 32'h0, lat, rd, f, m, t, beats);
    n_checks++;
    if (f !== 4'b0001) $display("FAIL cold_fill: got %b required 0001", f); else n_pass++;
    n_checks++;
    if (rd !== mem_word(32'h1000)) $display("FAIL cold_data: got %h required %h", rd, mem_word(32'h1000)); else n_pass++;
    n_checks++;
    if (beats !== 32) $display("FAIL cold_beats: got %0d required 32", beats); else n_pass++;
`ifdef DCACHE_CTRL_STATS_EN
    n_checks++;
    if ({stat_hits, stat_misses} !== {32'd1, 32'd1}) $display("FAIL cold_stats: got %0d/%0d required 1/1", stat_hits, stat_misses); else n_pass++;
`endif
  endtask

  task automatic test_hit();
    int lat, beats; logic [31:0] rd; logic [3:0] f, m; logic t;
    cpu_op(32'h0000_1004, 1'b0, 32'h0, lat, rd, f, m, t, beats);
    n_checks++;
    if (lat !== 3) $display("FAIL hit_latency: got %0d required 3", lat); else n_pass++;
    n_checks++;
    if ({f, t} !== 5'd0) $display("FAIL hit_no_fill: fill=%b traffic=%b required 0", f, t); else n_pass++;
    n_checks++;
    if (rd !== mem_word(32'h1004)) $display("FAIL hit_data: got %h required %h", rd, mem_word(32'h1004)); else n_pass++;
    n_checks++;
    if (dut.ttl[0] !== 8'd255) $display("FAIL hit_ttl0: got %0d required 255", dut.ttl[0]); else n_pass++;
  endtask

  task automatic test_write_hit();
    int lat, beats; logic [31:0] rd; logic [3:0] f, m; logic t;
    cpu_op(32'h0000_1008, 1'b1, 32'hDEAD_BEEF, lat, rd, f, m, t, beats);
    n_checks++;
    if (lat !== 3) $display("FAIL write_latency: got %0d required 3", lat); else n_pass++;
    n_checks++;
    if ({f, t} !== 5'd0) $display("FAIL write_no_mem: fill=%b traffic=%b required 0", f, t); else n_pass++;
    cpu_op(32'h0000_1008, 1'b0, 32'h0, lat, rd, f, m, t, beats);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL write_readback: got %h required deadbeef", rd); else n_pass++;
  endtask

  task automatic test_idle_pulses();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_valid = 1'b1;
      #1;
      n_checks++;
      if ({line_mem_valid, mem_rdreq} !== 5'd0) $display("FAIL idle_pulse%0d: got %b required 0", k, {line_mem_valid, mem_rdreq}); else n_pass++;
      @(negedge clk);
      mem_valid = 1'b0;
    end
  endtask

  task automatic test_eviction();
    int lat, beats; logic [31:0] rd; logic [3:0] f, m; logic t;
    logic [31:0] addrs [4] = '{32'h2000, 32'h3000, 32'h4000, 32'h5000};
    logic [3:0]  exp_f [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      cpu_op(addrs[k] + 32'h10, 1'b0, 32'h0, lat, rd, f, m, t, beats);
      n_checks++;
      if (f !== exp_f[k]) $display("FAIL evict_fill%0d: got %b required %b", k, f, exp_f[k]); else n_pass++;
      n_checks++;
      if (m !== exp_f[k]) $display("FAIL evict_lmv%0d: got %b required %b", k, m, exp_f[k]); else n_pass++;
      n_checks++;
      if (rd !== mem_word(addrs[k] + 32'h10)) $display("FAIL evict_data%0d: got %h required %h", k, rd, mem_word(addrs[k] + 32'h10)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_fill();
    int lat, beats, cyc; logic [31:0] rd; logic [3:0] f, m; logic t;
    @(posedge clk); #1;
    cpu_addr = 32'h0000_6000; cpu_rdreq = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 10 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (mem_rdreq) begin mem_valid = 1'b1; beats++; end
      else mem_valid = 1'b0;
    end
    n_checks++;
    if (beats !== 10) $display("FAIL midfill_reach_beat10: got %0d required 10", beats); else n_pass++;
    #2;
    reset_n = 1'b0; cpu_rdreq = 1'b0; mem_valid = 1'b0;
    #1;
    n_checks++;
    if ({cpu_ack, dcache_rdreq, line_fill, line_mem_valid, mem_rdreq, mem_wrreq, mem_addr} !== 43'd0)
      $display("FAIL midfill_async_clear: fill=%b lmv=%b rd=%b addr=%h required all 0", line_fill, line_mem_valid, mem_rdreq, mem_addr);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_ack, line_fill, line_mem_valid, mem_rdreq, mem_addr, cpu_dataout} !== 73'd0)
      $display("FAIL midfill_next_edge: fill=%b rd=%b dout=%h required all 0", line_fill, mem_rdreq, cpu_dataout);
    else n_pass++;
`ifdef DCACHE_CTRL_STATS_EN
    n_checks++;
    if ({stat_hits, stat_misses} !== 64'h0) $display("FAIL midfill_stats: got %0d/%0d required 0/0", stat_hits, stat_misses); else n_pass++;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    cpu_op(32'h0000_6000, 1'b0, 32'h0, lat, rd, f, m, t, beats);
    n_checks++;
    if (f !== 4'b0001) $display("FAIL refill_line: got %b required 0001", f); else n_pass++;
    n_checks++;
    if (beats !== 32) $display("FAIL refill_beats: got %0d required 32", beats); else n_pass++;
    n_checks++;
    if (rd !== mem_word(32'h6000)) $display("FAIL refill_data: got %h required %h", rd, mem_word(32'h6000)); else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_addr = '0; cpu_datain = '0; cpu_rdreq = 1'b0; cpu_wrreq = 1'b0; mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_cold_read();
    test_hit();
    test_write_hit();
    test_idle_pulses();
    test_eviction();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
